fp_norm_round_pipe: RTL and testbench

- Parametrised, 2-stage pipelined normalize-and-round back end for the FP add/sub datapath.
- Accepts the raw adder result: carry, hidden bit, fraction, G/R/S, pre-normalization exponent and sign.
- Produces a packed IEEE-style result using round-to-nearest-even.
- Handles overflow to infinity, underflow flush-to-zero and exact zero, with valid/ready flow control on both sides.

---
 rtl/fp_norm_round_pipe.sv | 153 +++++++++++++++
 tb/tb_fp_norm_round_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe
//   Two-stage normalize + round-to-nearest-even back end for the FP add/sub
//   datapath. Stage 1 normalizes the raw adder mantissa. Stage 2 rounds it,
//   selects zero/inf/flush/normal, and registers the packed result.
//
//   Optional build macro: FPNR_FLAGS_EN adds the out_flags port.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = pipeline advance)
//   in_mant             {carry, hidden, fraction[MAN_W-1:0], G, R, S}
//   in_exp              biased exponent before normalization
//   in_sign             result sign
//   out_valid/out_ready output handshake
//   out_result          {sign, exponent, fraction}
//   out_flags           {overflow, underflow, inexact, zero} (FPNR_FLAGS_EN)
module fp_norm_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W+4:0]       in_mant,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic                   in_sign,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result
`ifdef FPNR_FLAGS_EN
  ,
  output logic [3:0]             out_flags
`endif
);

  localparam int STAGES = 2;
  localparam int XW     = EXP_W + 2;          // signed internal exponent
  localparam int LZW    = $clog2(MAN_W + 2);  // holds 0..MAN_W+1
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  // Normalized mantissa is {hidden, fraction, G, R, S}.
  typedef struct packed {
    logic                  sign;
    logic                  zero;
    logic signed [XW-1:0]  exp;
    logic [MAN_W+3:0]      mant;
  } s1_t;

  logic              adv;
  logic [STAGES:1]   vld_pipe_d, vld_pipe_q;
  s1_t               s1_n, s1_d, s1_q;
  logic [EXP_W+MAN_W:0] res_n, res_d, res_q;
  logic [LZW-1:0]    lzc;
  logic signed [XW-1:0] base_exp;

  assign adv        = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready   = adv;
  assign out_valid  = vld_pipe_q[STAGES];
  assign out_result = res_q;

  // ---- stage 1: normalize ----
  always_comb begin
    // Highest set bit of {hidden, fraction} wins (ascending scan, last hit).
    lzc = LZW'(MAN_W + 1);
    for (int i = 0; i <= MAN_W; i++)
      if (in_mant[i+3]) lzc = LZW'(MAN_W - i);

    base_exp  = $signed({2'b00, in_exp});
    s1_n      = '0;
    s1_n.sign = in_sign;
    s1_n.zero = (in_mant == '0);
    if (!s1_n.zero) begin
      if (in_mant[MAN_W+4]) begin
        // Right shift by one; the bit falling off R joins the sticky.
        s1_n.mant = {in_mant[MAN_W+4:2], |in_mant[1:0]};
        s1_n.exp  = base_exp + XW'(1);
      end else if (in_mant[MAN_W+3]) begin
        s1_n.mant = in_mant[MAN_W+3:0];
        s1_n.exp  = base_exp;
      end else begin
        // Cancellation: G/R/S move up behind the LSB, zeros fill in.
        s1_n.mant = in_mant[MAN_W+3:0] << lzc;
        s1_n.exp  = base_exp - XW'(lzc);
      end
    end
  end

  // ---- stage 2: round (RNE) and result select ----
  logic                 r_up, r_ovf, r_unf, r_inx;
  logic [MAN_W+1:0]     r_sum;
  logic signed [XW-1:0] r_exp;
  logic [MAN_W-1:0]     r_frac;

  always_comb begin
    r_up   = s1_q.mant[2] & (s1_q.mant[1] | s1_q.mant[0] | s1_q.mant[3]);
    r_sum  = {1'b0, s1_q.mant[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, r_up};
    r_exp  = s1_q.exp;
    r_frac = r_sum[MAN_W-1:0];
    if (r_sum[MAN_W+1]) begin
      // Round carried past the hidden bit: renormalize.
      r_frac = r_sum[MAN_W:1];
      r_exp  = s1_q.exp + XW'(1);
    end
    r_inx = |s1_q.mant[2:0];
    r_ovf = 1'b0;
    r_unf = 1'b0;
    res_n = {s1_q.sign, r_exp[EXP_W-1:0], r_frac};
    if (s1_q.zero) begin
      res_n = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (r_exp >= EXP_MAX) begin
      res_n = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_ovf = 1'b1;
    end else if (r_exp[XW-1] || (r_exp == '0)) begin
      res_n = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
      r_unf = 1'b1;
    end
  end

  // ---- pipeline registers: everything holds while stalled ----
  always_comb begin
    vld_pipe_d = adv ? {vld_pipe_q[STAGES-1:1], in_valid} : vld_pipe_q;
    s1_d       = (adv && in_valid)    ? s1_n  : s1_q;
    res_d      = (adv && vld_pipe_q[1]) ? res_n : res_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      res_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
    end
  end

`ifdef FPNR_FLAGS_EN
  logic [3:0] flags_d, flags_q;
  always_comb
    flags_d = (adv && vld_pipe_q[1]) ? {r_ovf, r_unf, r_inx, s1_q.zero} : flags_q;
  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end
  assign out_flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = r_ovf ^ r_unf ^ r_inx;
`endif

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
module tb_fp_norm_round_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FPNR_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  always #5 clk = ~clk;

  fp_norm_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result)
`ifdef FPNR_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, n_push = 0, n_out = 0;
  int   stall_n = 0;
  bit   mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [27:0] mk(input logic c, input logic h,
                                     input logic [22:0] f, input logic [2:0] grs);
    return {c, h, f, grs};
  endfunction

  task automatic send(input logic [27:0] m, input logic [7:0] e, input logic s,
                      input logic [31:0] r, input logic [3:0] f,
                      input bit push, input bit lat);
    int w = 0;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1; in_mant = m; in_exp = e; in_sign = s;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    else if (push) begin
      x.res = r; x.flg = f; x.cyc = cyc; x.lat = lat;
      sb.push_back(x);
      n_push++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin @(negedge clk); w++; end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // out_ready: changed only just after the rising edge, so it is stable
  // when the driver and monitor sample on the falling edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (stall_n == 0);
      if (stall_n > 0) stall_n--;
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset && mon_en && out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out", {32'd0, out_result}, 64'hDEAD);
        end else if (out_ready) begin
          x = sb.pop_front();
          chk("result", {32'd0, out_result}, {32'd0, x.res});
`ifdef FPNR_FLAGS_EN
          chk("flags", {60'd0, out_flags}, {60'd0, x.flg});
`endif
          if (x.lat) chk("latency", 64'(cyc - x.cyc), 64'd2);
          n_out++;
        end else begin
          chk("stall_hold", {32'd0, out_result}, {32'd0, sb[0].res});
          chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_sign = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_result", {32'd0, out_result}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors, isolated so latency is exactly two cycles.
    send(mk(1,1,23'h0,3'b000),      8'h7F, 0, 32'h40400000, 4'b0000, 1, 1); drain();
    send(mk(0,1,23'h0,3'b100),      8'h7F, 0, 32'h3F800000, 4'b0010, 1, 1); drain();
    send(mk(0,1,23'h1,3'b100),      8'h7F, 0, 32'h3F800002, 4'b0010, 1, 1); drain();
    send(mk(0,1,23'h7FFFFF,3'b100), 8'h7F, 0, 32'h40000000, 4'b0010, 1, 1); drain();
    send(mk(0,0,23'h200000,3'b000), 8'h7F, 0, 32'h3E800000, 4'b0000, 1, 1); drain();
    send(mk(0,0,23'h0,3'b000),      8'h45, 1, 32'h80000000, 4'b0001, 1, 1); drain();
    send(mk(1,1,23'h0,3'b000),      8'hFE, 0, 32'h7F800000, 4'b1000, 1, 1); drain();
    send(mk(0,0,23'h1,3'b000),      8'h05, 0, 32'h00000000, 4'b0100, 1, 1); drain();

    // Boundaries and more rounding, streamed back to back.
    send(mk(0,1,23'h0,3'b000),      8'h01, 0, 32'h00800000, 4'b0000, 1, 0);
    send(mk(0,1,23'h0,3'b000),      8'h00, 1, 32'h80000000, 4'b0100, 1, 0);
    send(mk(0,1,23'h0,3'b000),      8'hFE, 0, 32'h7F000000, 4'b0000, 1, 0);
    send(mk(0,1,23'h7FFFFF,3'b100), 8'hFE, 0, 32'h7F800000, 4'b1010, 1, 0);
    send(mk(0,1,23'h0,3'b110),      8'h7F, 0, 32'h3F800001, 4'b0010, 1, 0);
    send(mk(0,1,23'h0,3'b011),      8'h7F, 1, 32'hBF800000, 4'b0010, 1, 0);
    send(mk(1,1,23'h1,3'b000),      8'h7F, 0, 32'h40400000, 4'b0010, 1, 0);
    drain();

    // Backpressure: 3-cycle out_ready stall in the middle of 4 beats.
    fork
      begin
        send(mk(0,1,23'h000001,3'b000), 8'h80, 0, 32'h40000001, 4'b0000, 1, 0);
        send(mk(0,1,23'h000002,3'b000), 8'h80, 0, 32'h40000002, 4'b0000, 1, 0);
        send(mk(0,1,23'h000003,3'b000), 8'h80, 0, 32'h40000003, 4'b0000, 1, 0);
        send(mk(0,1,23'h000004,3'b000), 8'h80, 0, 32'h40000004, 4'b0000, 1, 0);
      end
      begin
        repeat (3) @(negedge clk);
        stall_n = 3;
      end
    join
    drain();

    // Reset with two beats in flight: they must vanish.
    mon_en = 1'b0;
    send(mk(0,1,23'h0000AA,3'b000), 8'h81, 0, 32'h0, 4'b0000, 0, 0);
    send(mk(0,1,23'h0000BB,3'b000), 8'h81, 0, 32'h0, 4'b0000, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_result", {32'd0, out_result}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_no_ghost", {63'd0, out_valid}, 64'd0);
    mon_en = 1'b1;
    send(mk(0,1,23'h000010,3'b000), 8'h7F, 0, 32'h3F800010, 4'b0000, 1, 1);
    send(mk(0,1,23'h000020,3'b000), 8'h7F, 1, 32'hBF800020, 4'b0000, 1, 0);
    drain();
    repeat (3) @(negedge clk);
    chk("out_count", 64'(n_out), 64'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
